bus_initiator: RTL and testbench

CPU-side load/store initiator for the shared data bus: accepts one memory request at a time from the core over a valid/ready handshake. It drives `rw`/`addr`/`write` to the data bus, holds them stable across a configurable number of slow-bus ticks, then captures `read` and `exception` and returns a one-cycle response. It sits between `zipocpu` and `data_bus`, which runs off the divided clock. The block stays on the fast clock and paces itself with a one-cycle `bus_tick` strobe marking each slow-bus edge.

---
 rtl/bus_initiator.sv | 123 ++++++++++++
 tb/tb_bus_initiator.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// bus_initiator: one-at-a-time load/store initiator that holds a request on the slow data bus for a set number of bus ticks.
module bus_initiator #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int HOLD_TICKS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_tick,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_fault,
  output logic                  rw,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] write,
  input  logic [DATA_WIDTH-1:0] read,
  input  logic                  exception
);
  localparam int CW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [1:0] {IDLE, SETUP, HOLD, RESP} state_t;
  state_t state_q, state_d;
  logic ready_q, ready_d, rw_q, rw_d, valid_q, valid_d, fault_q, fault_d;
  logic [1:0] size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] write_q, write_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mis, last;
  function automatic logic [DATA_WIDTH-1:0] mask_f(input logic [1:0] s, input logic [DATA_WIDTH-1:0] d);
    return d & ({DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << s)));
  endfunction
  assign mis = (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && |req_addr[1:0]) ||
               (req_size == 2'd3 && |req_addr[2:0]);
  // The tick that brings the counter to HOLD_TICKS is the capture tick.
  assign last = cnt_q == CW'(HOLD_TICKS - 1);
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    write_d = write_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        ready_d = 1'b0;
        if (mis) begin
          state_d = RESP;
          valid_d = 1'b1;
          fault_d = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = SETUP;
          rw_d    = req_rw;
          size_d  = req_size;
          addr_d  = req_addr;
          write_d = mask_f(req_size, req_wdata);
        end
      end
      SETUP: if (bus_tick) begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: if (bus_tick) begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = RESP;
          valid_d = 1'b1;
          rdata_d = rw_q ? '0 : mask_f(size_q, read);
          fault_d = exception;
          rw_d    = 1'b0;
          addr_d  = '0;
          write_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      rw_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      write_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;
  assign rw        = rw_q;
  assign addr      = addr_q;
  assign write     = write_q;
endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed scoreboard bench for bus_initiator with HOLD_TICKS=2 and a bus tick every 4 cycles.
module tb_bus_initiator;
  logic clk = 0, rst_n = 1, bus_tick = 0, req_valid = 0, req_rw = 0, exception = 0;
  logic [1:0] req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0, read = 0;
  logic req_ready, rsp_valid, rsp_fault, rw;
  logic [63:0] rsp_rdata, addr, write;
  int n_vec = 0, n_err = 0, ph = 0, ticks = 0, exc_at = 99;
  logic [64:0] q[$];

  bus_initiator #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus_tick(bus_tick), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .rw(rw), .addr(addr), .write(write), .read(read), .exception(exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; count ticks the DUT sampled and schedule the next tick/exception.
  task automatic tick_cycle();
    logic t;
    t = bus_tick;
    @(posedge clk);
    #1;
    if (t) ticks++;
    ph = (ph + 1) % 4;
    bus_tick = (ph == 0);
    exception = bus_tick && (ticks + 1 == exc_at);
  endtask

  task automatic txn(input string tag, input logic rw_i, input logic [1:0] sz, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] rd, input logic [63:0] exp_rd,
                     input logic exp_f, input int exp_t, input int exp_n, input logic exp_rw,
                     input logic [63:0] exp_a, input logic [63:0] exp_w, input bit co);
    int n;
    bit st;
    n = 0;
    while (!req_ready && n < 50) begin tick_cycle(); n++; end
    chk({tag, "_ready_in"}, req_ready, 1);
    if (co) begin ph = 3; bus_tick = 1; end
    req_valid = 1; req_rw = rw_i; req_size = sz; req_addr = a; req_wdata = wd; read = rd;
    q.push_back({exp_rd, exp_f});
    ticks = bus_tick ? -1 : 0;
    tick_cycle();
    req_valid = 0;
    n = 0;
    st = 1;
    while (!rsp_valid && n < 40) begin
      st &= (rw === exp_rw && addr === exp_a && write === exp_w);
      tick_cycle();
      n++;
    end
    chk({tag, "_rsp"}, rsp_valid, 1);
    chk({tag, "_ticks"}, ticks, exp_t);
    chk({tag, "_held"}, st, 1);
    if (exp_n >= 0) chk({tag, "_cycles"}, n, exp_n);
    chk({tag, "_resp_bus"}, addr | write | {63'b0, rw}, 0);
    chk({tag, "_busy"}, req_ready, 0);
    tick_cycle();
    chk({tag, "_one_shot"}, rsp_valid, 0);
    chk({tag, "_ready_back"}, req_ready, 1);
  endtask

  always @(negedge clk) if (rsp_valid) begin
    if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
    else begin
      logic [64:0] e;
      e = q.pop_front();
      chk("sb_rdata", rsp_rdata, e[64:1]);
      chk("sb_fault", rsp_fault, e[0]);
    end
  end

  initial begin
    int n;
    #1 rst_n = 0;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_fault", rsp_fault, 0);
    chk("rst_rw", rw, 0);
    chk("rst_addr", addr, 0);
    chk("rst_write", write, 0);
    repeat (2) tick_cycle();
    rst_n = 1;
    txn("rd64", 0, 3, 64'h10, 0, 64'h1122334455667788, 64'h1122334455667788, 0, 3, -1, 0, 64'h10, 0, 0);
    txn("wr8", 1, 0, 64'h3, 64'hFFFFFFFFFFFFFFA5, 64'hDEADBEEF, 0, 0, 3, -1, 1, 64'h3, 64'hA5, 0);
    txn("misal", 0, 2, 64'h6, 64'h55, 64'h77, 0, 1, 0, 0, 0, 0, 0, 0);
    exc_at = 2;
    txn("exc2", 0, 2, 64'h8, 0, 64'hCAFEF00D12345678, 64'h12345678, 0, 3, -1, 0, 64'h8, 0, 0);
    exc_at = 3;
    txn("exc3", 0, 3, 64'h18, 0, 64'hA5A5, 64'hA5A5, 1, 3, -1, 0, 64'h18, 0, 0);
    exc_at = 99;
    n = 0;
    while (!req_ready && n < 50) begin tick_cycle(); n++; end
    req_valid = 1; req_rw = 0; req_size = 3; req_addr = 64'h20; read = 64'h5555;
    ticks = bus_tick ? -1 : 0;
    tick_cycle();
    req_valid = 0;
    n = 0;
    while (ticks < 2 && n < 40) begin tick_cycle(); n++; end
    chk("rst_mid_reach_hold", ticks, 2);
    chk("rst_mid_pre_addr", addr, 64'h20);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_bus", addr | write | {63'b0, rw}, 0);
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_ready", req_ready, 1);
    repeat (2) tick_cycle();
    rst_n = 1;
    txn("rd16", 0, 1, 64'h2, 0, 64'h123456789ABCBEEF, 64'hBEEF, 0, 3, -1, 0, 64'h2, 0, 0);
    txn("coinc", 0, 3, 64'h40, 0, 64'h0F0F, 64'h0F0F, 0, 3, 9, 0, 64'h40, 0, 1);
    repeat (3) tick_cycle();
    chk("sb_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
